cache_fill_controller: RTL and testbench
========================================

Name: cache_fill_controller

Overview:
Controller for one direct-mapped read-cache set. It sits between a CPU read port and backing memory. On a hit it returns set data in the same cycle. On a miss it fetches the word from memory, writes it into the set and forwards it to the CPU. It also invalidates every line of the set after reset and on request.

Parameters:
DATA_WIDTH, 32, data word width in bits
TAG_WIDTH, 3, tag width in bits
INDEX_WIDTH, 5, set index width in bits; the set holds 2^INDEX_WIDTH lines
ADDR_WIDTH (localparam), TAG_WIDTH+INDEX_WIDTH+2, byte address width

Ports:
i_clock  in  1  clock; all state changes on the rising edge
i_reset  in  1  asynchronous, active-high reset
i_rd  in  1  CPU read request; CPU holds it until o_valid
i_addr  in  ADDR_WIDTH  CPU byte address; CPU holds it stable until o_valid; [1:0] ignored
i_flush  in  1  request to invalidate the whole set
o_data  out  DATA_WIDTH  read data to the CPU
o_valid  out  1  o_data valid; completes the CPU request
o_busy  out  1  controller is not in IDLE
o_set_index  out  INDEX_WIDTH  set index
o_set_tag  out  TAG_WIDTH  set tag
o_set_data  out  DATA_WIDTH  set write data
o_set_wr  out  1  set line write (valid=1, tag)
o_set_cl  out  1  set line invalidate
i_set_data  in  DATA_WIDTH  set read data; asynchronous-read storage
i_set_hit  in  1  set hit; combinational from index/tag; forced 0 by the set while wr/cl is asserted
o_mem_addr  out  ADDR_WIDTH  memory word address, [1:0]=0
o_mem_rd  out  1  memory read request
i_mem_data  in  DATA_WIDTH  memory read data
i_mem_ready  in  1  memory data valid; sampled only while o_mem_rd=1

Behaviour:
- Address split: index = i_addr[INDEX_WIDTH+1:2]; tag = i_addr[ADDR_WIDTH-1:INDEX_WIDTH+2].
- States: INIT, IDLE, FILL, WRITE, FLUSH. State, counter, latched address, captured data and flush_pending are registers.
- Reset (asynchronous) sets state=INIT, counter=0, flush_pending=0. Outputs immediately go to: o_mem_rd=0, o_set_wr=0, o_valid=0, o_busy=1, o_data=0.
- INIT and FLUSH:
  - Each cycle drive o_set_cl=1, o_set_index=counter, o_set_tag=0, and increment counter.
  - In the cycle counter=2^INDEX_WIDTH-1, clear counter and flush_pending, then go to IDLE.
  - Total duration is exactly 2^INDEX_WIDTH cycles (32 with defaults). i_rd is ignored and o_valid=0.
- IDLE:
  - Drive o_set_index and o_set_tag from i_addr; o_busy=0.
  - Priority order: flush_pending or i_flush goes to FLUSH first; otherwise i_rd with i_set_hit; otherwise i_rd without a hit.
  - i_rd with i_set_hit: o_valid=1 and o_data=i_set_data combinationally (zero-latency hit). Stay in IDLE.
  - i_rd without a hit: latch i_addr, then go to FILL.
- FILL:
  - o_mem_rd=1 and o_mem_addr={latched[ADDR_WIDTH-1:2],2'b00}, held stable until i_mem_ready=1.
  - On the ready cycle, capture i_mem_data and go to WRITE.
  - Wait time is unbounded; there is no timeout.
- WRITE:
  - o_set_wr=1, with o_set_index and o_set_tag from the latched address and o_set_data=captured data.
  - o_valid=1 and o_data=captured data in the same cycle. Next state is IDLE.
  - Miss latency, counted from the first i_rd cycle in IDLE to o_valid: 2 + (number of FILL cycles).
- i_flush asserted in FILL or WRITE sets flush_pending. The flush runs after WRITE, and the in-flight fill still completes and delivers o_valid.
- i_flush in INIT or FLUSH is ignored.
- o_set_wr and o_set_cl are never both 1. o_mem_rd=1 only in FILL.
- When not in IDLE and not in WRITE, o_data=0.
- Reset mid-FILL: o_mem_rd drops asynchronously and the latched request is discarded. The CPU must reissue it.

Test Plan:
1. Reset, then hold i_rd=0 -> o_set_cl=1 for exactly 32 cycles with index 0..31, o_busy=1 throughout, then IDLE with o_busy=0.
2. After init, i_rd with addr 0x0000_0044 and memory ready after 3 cycles returning 0xDEADBEEF:
   - o_mem_addr=0x44 while o_mem_rd=1.
   - The WRITE cycle shows index=17, tag=0, o_valid=1, o_data=0xDEADBEEF.
   - A repeat read of 0x44 gives o_valid=1 in the same cycle, with o_mem_rd staying 0.
3. Read 0xC4 (same index 17, tag 1) after step 2 -> miss, memory fetch, index 17 overwritten; a re-read of 0x44 then misses.
4. Pulse i_flush in IDLE -> 32 invalidate cycles; the next read of 0xC4 misses.
5. Pulse i_flush during FILL:
   - The fill completes and o_valid=1 carries the memory data.
   - The next cycle enters FLUSH for 32 cycles, then IDLE.
6. Assert i_reset in the second FILL cycle -> o_mem_rd=0 immediately, INIT runs, and no o_valid occurs for the aborted request.

Source files
------------

// File: rtl/cache_fill_controller.sv
// Fill controller for one direct-mapped read-cache set.
// Hits return set data combinationally. Misses fetch the word from memory,
// write it into the set and forward it to the CPU in the same WRITE cycle.
// The whole set is invalidated after reset and on a flush request.
module cache_fill_controller #(
    parameter  int DATA_WIDTH  = 32,
    parameter  int TAG_WIDTH   = 3,
    parameter  int INDEX_WIDTH = 5,
    localparam int ADDR_WIDTH  = TAG_WIDTH + INDEX_WIDTH + 2
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic                   i_rd,
    input  logic [ADDR_WIDTH-1:0]  i_addr,
    input  logic                   i_flush,
    output logic [DATA_WIDTH-1:0]  o_data,
    output logic                   o_valid,
    output logic                   o_busy,
    output logic [INDEX_WIDTH-1:0] o_set_index,
    output logic [TAG_WIDTH-1:0]   o_set_tag,
    output logic [DATA_WIDTH-1:0]  o_set_data,
    output logic                   o_set_wr,
    output logic                   o_set_cl,
    input  logic [DATA_WIDTH-1:0]  i_set_data,
    input  logic                   i_set_hit,
    output logic [ADDR_WIDTH-1:0]  o_mem_addr,
    output logic                   o_mem_rd,
    input  logic [DATA_WIDTH-1:0]  i_mem_data,
    input  logic                   i_mem_ready
);

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        FILL,
        WRITE,
        FLUSH
    } state_t;

    localparam logic [INDEX_WIDTH-1:0] LAST_INDEX = {INDEX_WIDTH{1'b1}};

    state_t                 state_q, state_d;
    logic [INDEX_WIDTH-1:0] counter_q, counter_d;
    logic                   flush_pending_q, flush_pending_d;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [DATA_WIDTH-1:0]  data_q;
    logic                   addr_load;
    logic                   data_load;

    // Control state: FSM, invalidate counter and deferred flush request.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q         <= INIT;
            counter_q       <= '0;
            flush_pending_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            counter_q       <= counter_d;
            flush_pending_q <= flush_pending_d;
        end
    end

    // Miss address and fetched word; only consumed after being loaded in this request.
    always_ff @(posedge i_clock) begin
        if (addr_load) begin
            addr_q <= i_addr;
        end
        if (data_load) begin
            data_q <= i_mem_data;
        end
    end

    // Next-state logic and all outputs.
    always_comb begin
        state_d         = state_q;
        counter_d       = counter_q;
        flush_pending_d = flush_pending_q;
        addr_load       = 1'b0;
        data_load       = 1'b0;
        o_data          = '0;
        o_valid         = 1'b0;
        o_busy          = 1'b1;
        o_set_index     = '0;
        o_set_tag       = '0;
        o_set_data      = '0;
        o_set_wr        = 1'b0;
        o_set_cl        = 1'b0;
        o_mem_addr      = {addr_q[ADDR_WIDTH-1:2], 2'b00};
        o_mem_rd        = 1'b0;

        unique case (state_q)
            INIT, FLUSH: begin
                // Walk every line of the set, one invalidate per cycle.
                o_set_cl    = 1'b1;
                o_set_index = counter_q;
                counter_d   = counter_q + INDEX_WIDTH'(1);
                if (counter_q == LAST_INDEX) begin
                    counter_d       = '0;
                    flush_pending_d = 1'b0;
                    state_d         = IDLE;
                end
            end
            IDLE: begin
                o_busy      = 1'b0;
                o_set_index = i_addr[INDEX_WIDTH+1:2];
                o_set_tag   = i_addr[ADDR_WIDTH-1:INDEX_WIDTH+2];
                if (flush_pending_q || i_flush) begin
                    state_d = FLUSH;
                end else if (i_rd && i_set_hit) begin
                    o_valid = 1'b1;
                    o_data  = i_set_data;
                end else if (i_rd) begin
                    addr_load = 1'b1;
                    state_d   = FILL;
                end
            end
            FILL: begin
                o_mem_rd = 1'b1;
                if (i_flush) begin
                    flush_pending_d = 1'b1;
                end
                if (i_mem_ready) begin
                    data_load = 1'b1;
                    state_d   = WRITE;
                end
            end
            WRITE: begin
                // Install the fetched line and complete the CPU read together.
                o_set_wr    = 1'b1;
                o_set_index = addr_q[INDEX_WIDTH+1:2];
                o_set_tag   = addr_q[ADDR_WIDTH-1:INDEX_WIDTH+2];
                o_set_data  = data_q;
                o_valid     = 1'b1;
                o_data      = data_q;
                // A flush requested during the fill starts right after this cycle.
                if (flush_pending_q || i_flush) begin
                    flush_pending_d = 1'b1;
                    state_d         = FLUSH;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = INIT;
            end
        endcase
    end

endmodule

// File: tb/tb_cache_fill_controller.sv
// Directed bench for cache_fill_controller with a behavioural set store.
module tb_cache_fill_controller;

    localparam int DW = 32;
    localparam int TW = 3;
    localparam int IW = 5;
    localparam int AW = TW + IW + 2;
    localparam int LINES = 1 << IW;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          rd = 1'b0;
    logic [AW-1:0] addr = '0;
    logic          flush = 1'b0;
    logic [DW-1:0] o_data;
    logic          o_valid;
    logic          o_busy;
    logic [IW-1:0] o_set_index;
    logic [TW-1:0] o_set_tag;
    logic [DW-1:0] o_set_data;
    logic          o_set_wr;
    logic          o_set_cl;
    logic [DW-1:0] set_data;
    logic          set_hit;
    logic [AW-1:0] o_mem_addr;
    logic          o_mem_rd;
    logic [DW-1:0] mem_data = '0;
    logic          mem_ready = 1'b0;

    int total = 0;
    int bad   = 0;

    // Set storage: asynchronous read, written on the clock edge.
    logic          mdl_valid [LINES];
    logic [TW-1:0] mdl_tag   [LINES];
    logic [DW-1:0] mdl_data  [LINES];

    always #5 clk = ~clk;

    cache_fill_controller dut (
        .i_clock     (clk),
        .i_reset     (rst),
        .i_rd        (rd),
        .i_addr      (addr),
        .i_flush     (flush),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .o_busy      (o_busy),
        .o_set_index (o_set_index),
        .o_set_tag   (o_set_tag),
        .o_set_data  (o_set_data),
        .o_set_wr    (o_set_wr),
        .o_set_cl    (o_set_cl),
        .i_set_data  (set_data),
        .i_set_hit   (set_hit),
        .o_mem_addr  (o_mem_addr),
        .o_mem_rd    (o_mem_rd),
        .i_mem_data  (mem_data),
        .i_mem_ready (mem_ready)
    );

    assign set_data = mdl_data[o_set_index];
    assign set_hit  = mdl_valid[o_set_index] && (mdl_tag[o_set_index] == o_set_tag)
                      && !o_set_wr && !o_set_cl;

    // Set storage update from the controller's write/invalidate strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < LINES; k++) mdl_valid[k] <= 1'b0;
        end else if (o_set_wr) begin
            mdl_valid[o_set_index] <= 1'b1;
            mdl_tag[o_set_index]   <= o_set_tag;
            mdl_data[o_set_index]  <= o_set_data;
        end else if (o_set_cl) begin
            mdl_valid[o_set_index] <= 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expect a full 32-cycle invalidate sweep followed by IDLE.
    task automatic run_clear(input string tag);
        for (int i = 0; i < LINES; i++) begin
            #1;
            chk({tag, "_cl"}, 32'(o_set_cl), 32'd1);
            chk({tag, "_idx"}, 32'(o_set_index), 32'(i));
            chk({tag, "_busy"}, 32'(o_busy), 32'd1);
            chk({tag, "_valid"}, 32'(o_valid), 32'd0);
            chk({tag, "_data"}, o_data, 32'd0);
            tick();
        end
        #1;
        chk({tag, "_idle_busy"}, 32'(o_busy), 32'd0);
        chk({tag, "_idle_cl"}, 32'(o_set_cl), 32'd0);
    endtask

    initial begin
        // Reset and init sweep
        #1 rst = 1'b1;
        #1;
        chk("rst_busy", 32'(o_busy), 32'd1);
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_mem_rd", 32'(o_mem_rd), 32'd0);
        chk("rst_set_wr", 32'(o_set_wr), 32'd0);
        chk("rst_data", o_data, 32'd0);
        tick();
        tick();
        rst = 1'b0;
        run_clear("init");

        // Miss on 0x44, memory ready on the third FILL cycle
        rd = 1'b1;
        addr = 10'h044;
        mem_data = 32'hDEADBEEF;
        #1;
        chk("miss44_valid", 32'(o_valid), 32'd0);
        tick();
        for (int k = 0; k < 3; k++) begin
            mem_ready = (k == 2);
            #1;
            chk("fill44_mem_rd", 32'(o_mem_rd), 32'd1);
            chk("fill44_mem_addr", 32'(o_mem_addr), 32'h44);
            chk("fill44_valid", 32'(o_valid), 32'd0);
            chk("fill44_data", o_data, 32'd0);
            tick();
        end
        mem_ready = 1'b0;
        mem_data = 32'h0;
        #1;
        chk("wr44_set_wr", 32'(o_set_wr), 32'd1);
        chk("wr44_index", 32'(o_set_index), 32'd17);
        chk("wr44_tag", 32'(o_set_tag), 32'd0);
        chk("wr44_set_data", o_set_data, 32'hDEADBEEF);
        chk("wr44_valid", 32'(o_valid), 32'd1);
        chk("wr44_data", o_data, 32'hDEADBEEF);
        chk("wr44_mem_rd", 32'(o_mem_rd), 32'd0);
        tick();
        #1;
        chk("hit44_valid", 32'(o_valid), 32'd1);
        chk("hit44_data", o_data, 32'hDEADBEEF);
        chk("hit44_mem_rd", 32'(o_mem_rd), 32'd0);
        chk("hit44_busy", 32'(o_busy), 32'd0);
        rd = 1'b0;
        tick();

        // Same index, different tag: 0xC4 replaces line 17
        rd = 1'b1;
        addr = 10'h0C4;
        #1;
        chk("missC4_valid", 32'(o_valid), 32'd0);
        tick();
        mem_ready = 1'b1;
        mem_data = 32'h12345678;
        #1;
        chk("fillC4_mem_addr", 32'(o_mem_addr), 32'hC4);
        chk("fillC4_mem_rd", 32'(o_mem_rd), 32'd1);
        tick();
        mem_ready = 1'b0;
        #1;
        chk("wrC4_index", 32'(o_set_index), 32'd17);
        chk("wrC4_tag", 32'(o_set_tag), 32'd1);
        chk("wrC4_data", o_data, 32'h12345678);
        chk("wrC4_valid", 32'(o_valid), 32'd1);
        tick();
        addr = 10'h044;
        #1;
        chk("reread44_valid", 32'(o_valid), 32'd0);
        tick();
        mem_ready = 1'b1;
        mem_data = 32'hDEADBEEF;
        #1;
        chk("refill44_mem_rd", 32'(o_mem_rd), 32'd1);
        tick();
        mem_ready = 1'b0;
        #1;
        chk("rewr44_data", o_data, 32'hDEADBEEF);
        tick();
        rd = 1'b0;

        // Flush from IDLE
        flush = 1'b1;
        #1;
        chk("flush_idle_busy", 32'(o_busy), 32'd0);
        tick();
        flush = 1'b0;
        run_clear("flush");
        rd = 1'b1;
        addr = 10'h0C4;
        #1;
        chk("postflushC4_valid", 32'(o_valid), 32'd0);
        tick();

        // Flush pulse during FILL: fill completes, then FLUSH
        flush = 1'b1;
        #1;
        chk("ffill1_mem_rd", 32'(o_mem_rd), 32'd1);
        chk("ffill1_cl", 32'(o_set_cl), 32'd0);
        tick();
        flush = 1'b0;
        mem_ready = 1'b1;
        mem_data = 32'hCAFEF00D;
        #1;
        chk("ffill2_mem_rd", 32'(o_mem_rd), 32'd1);
        tick();
        mem_ready = 1'b0;
        #1;
        chk("fwr_valid", 32'(o_valid), 32'd1);
        chk("fwr_data", o_data, 32'hCAFEF00D);
        chk("fwr_set_wr", 32'(o_set_wr), 32'd1);
        chk("fwr_cl", 32'(o_set_cl), 32'd0);
        tick();
        rd = 1'b0;
        run_clear("fflush");

        // Reset in the second FILL cycle
        rd = 1'b1;
        addr = 10'h044;
        #1;
        chk("rmiss_valid", 32'(o_valid), 32'd0);
        tick();
        #1;
        chk("rfill1_mem_rd", 32'(o_mem_rd), 32'd1);
        tick();
        #1;
        chk("rfill2_mem_rd", 32'(o_mem_rd), 32'd1);
        rst = 1'b1;
        #1;
        chk("rabort_mem_rd", 32'(o_mem_rd), 32'd0);
        chk("rabort_valid", 32'(o_valid), 32'd0);
        chk("rabort_busy", 32'(o_busy), 32'd1);
        rd = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        run_clear("reinit");
        #1;
        chk("reinit_valid", 32'(o_valid), 32'd0);
        chk("reinit_mem_rd", 32'(o_mem_rd), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
